mem_port_arbiter: RTL and testbench

- Shares the single-port data memory (8-bit data, 32 words, synchronous write, 1-cycle registered read) between two requesters.
- Port 0 is the CPU control unit's load/store path; port 1 is the host/debug loader.
- Round-robin arbitration with an optional lock for atomic read-modify-write sequences.
- A lock-timeout counter prevents either port starving the other.

---
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory.
// A port may lock the memory for read-modify-write; locks are force-released after LOCK_MAX cycles.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5,
    parameter int LOCK_MAX   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  wen0,
    input  logic                  lock0,
    input  logic [ADDR_BITS-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    input  logic                  req1,
    input  logic                  wen1,
    input  logic                  lock1,
    input  logic [ADDR_BITS-1:0]  addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  lock_timeout
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= CNT_W'(LOCK_MAX)) begin
            return CNT_W'(LOCK_MAX);
        end
        return v + CNT_W'(1);
    endfunction

    logic                  last_q, last_d;
    logic                  lock_q, lock_d;
    logic                  owner_q, owner_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [ADDR_BITS-1:0]  mem_addr_p1_q, mem_addr_p1_d;
    logic                  mem_wen_p1_q, mem_wen_p1_d;
    logic [DATA_WIDTH-1:0] mem_din_p1_q, mem_din_p1_d;
    logic                  vld_p1_q, vld_p1_d;
    logic                  port_p1_q, port_p1_d;
    logic                  vld0_p2_q, vld0_p2_d;
    logic                  vld1_p2_q, vld1_p2_d;

    logic                  gnt0_c, gnt1_c;
    logic                  xfer, win, timeout;
    logic                  w_wen, w_lock;
    logic [ADDR_BITS-1:0]  w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q        <= 1'b1;
            lock_q        <= 1'b0;
            owner_q       <= 1'b0;
            cnt_q         <= '0;
            mem_addr_p1_q <= '0;
            mem_wen_p1_q  <= 1'b0;
            mem_din_p1_q  <= '0;
            vld_p1_q      <= 1'b0;
            port_p1_q     <= 1'b0;
            vld0_p2_q     <= 1'b0;
            vld1_p2_q     <= 1'b0;
        end else begin
            last_q        <= last_d;
            lock_q        <= lock_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            mem_addr_p1_q <= mem_addr_p1_d;
            mem_wen_p1_q  <= mem_wen_p1_d;
            mem_din_p1_q  <= mem_din_p1_d;
            vld_p1_q      <= vld_p1_d;
            port_p1_q     <= port_p1_d;
            vld0_p2_q     <= vld0_p2_d;
            vld1_p2_q     <= vld1_p2_d;
        end
    end

    // Grants depend only on requests and registered arbiter state.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (lock_q) begin
            if (owner_q) gnt1_c = req1;
            else         gnt0_c = req0;
        end else if (req0 && req1) begin
            if (last_q) gnt0_c = 1'b1;
            else        gnt1_c = 1'b1;
        end else begin
            gnt0_c = req0;
            gnt1_c = req1;
        end
    end

    assign xfer    = gnt0_c | gnt1_c;
    assign win     = gnt1_c;
    assign w_wen   = win ? wen1   : wen0;
    assign w_lock  = win ? lock1  : lock0;
    assign w_addr  = win ? addr1  : addr0;
    assign w_wdata = win ? wdata1 : wdata0;
    assign timeout = lock_q && (cnt_q == CNT_W'(LOCK_MAX));

    // A forced release hands the next tie to the non-owner; an owner re-lock does not restart the count.
    always_comb begin
        last_d  = last_q;
        lock_d  = lock_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (timeout) begin
            lock_d = 1'b0;
            cnt_d  = '0;
            last_d = owner_q;
        end else if (xfer) begin
            last_d = win;
            if (!lock_q) begin
                lock_d  = w_lock;
                owner_d = win;
                cnt_d   = '0;
            end else if (!w_lock) begin
                lock_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = sat_inc(cnt_q);
            end
        end else if (lock_q) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // p1: memory request stage
    always_comb begin
        mem_addr_p1_d = mem_addr_p1_q;
        mem_din_p1_d  = mem_din_p1_q;
        mem_wen_p1_d  = 1'b0;
        vld_p1_d      = 1'b0;
        port_p1_d     = port_p1_q;
        if (xfer) begin
            mem_addr_p1_d = w_addr;
            mem_din_p1_d  = w_wdata;
            mem_wen_p1_d  = w_wen;
            vld_p1_d      = !w_wen;
            port_p1_d     = win;
        end
    end

    // p2: read return stage
    always_comb begin
        vld0_p2_d = vld_p1_q && !port_p1_q;
        vld1_p2_d = vld_p1_q && port_p1_q;
    end

    assign gnt0         = gnt0_c;
    assign gnt1         = gnt1_c;
    assign mem_addr     = mem_addr_p1_q;
    assign mem_wen      = mem_wen_p1_q;
    assign mem_din      = mem_din_p1_q;
    assign rvalid0      = vld0_p2_q;
    assign rvalid1      = vld1_p2_q;
    assign rdata        = mem_dout;
    assign lock_timeout = timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port memory attached.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, wen0, lock0, req1, wen1, lock1;
    logic [4:0] addr0, addr1, mem_addr;
    logic [7:0] wdata0, wdata1, rdata, mem_din, mem_dout;
    logic       gnt0, gnt1, rvalid0, rvalid1, mem_wen, lock_timeout;
    logic       load_en;
    logic [7:0] mem_model [0:31];
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_WIDTH(8), .ADDR_BITS(5), .LOCK_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .wen0(wen0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .wen1(wen1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_din(mem_din),
        .mem_dout(mem_dout), .lock_timeout(lock_timeout)
    );

    // Synchronous-write, registered-read memory; preload happens while load_en is high.
    always @(posedge clk) begin
        if (load_en) begin
            mem_model[3] <= 8'h33;
            mem_model[4] <= 8'h44;
            mem_model[5] <= 8'hA5;
            mem_model[9] <= 8'h90;
        end else if (mem_wen) begin
            mem_model[mem_addr] <= mem_din;
        end
        mem_dout <= mem_model[mem_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic r, input logic w, input logic l,
                          input logic [4:0] a, input logic [7:0] d);
        req0 = r; wen0 = w; lock0 = l; addr0 = a; wdata0 = d;
    endtask

    task automatic drive1(input logic r, input logic w, input logic l,
                          input logic [4:0] a, input logic [7:0] d);
        req1 = r; wen1 = w; lock1 = l; addr1 = a; wdata1 = d;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        n_checks++; if (mem_addr !== 5'd0) $display("FAIL rst_mem_addr: got %0h expected 0", mem_addr); else n_pass++;
        n_checks++; if (mem_wen !== 1'b0) $display("FAIL rst_mem_wen: got %b expected 0", mem_wen); else n_pass++;
        n_checks++; if (mem_din !== 8'h00) $display("FAIL rst_mem_din: got %0h expected 0", mem_din); else n_pass++;
        n_checks++; if ({rvalid0, rvalid1} !== 2'b00) $display("FAIL rst_rvalid: got %b%b expected 00", rvalid0, rvalid1); else n_pass++;
        n_checks++; if (lock_timeout !== 1'b0) $display("FAIL rst_lock_timeout: got %b expected 0", lock_timeout); else n_pass++;
        rst = 1'b1;
        load_en = 1'b0;
        tick();
        #1;
        n_checks++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL rst_idle_gnt: got %b%b expected 00", gnt0, gnt1); else n_pass++;
    endtask

    task automatic test_single_read;
        tick(); drive0(1'b1, 1'b0, 1'b0, 5'd5, 8'h00); #1;
        n_checks++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL rd_gnt: got %b%b expected 10", gnt0, gnt1); else n_pass++;
        tick(); drive0(1'b0, 1'b0, 1'b0, 5'd0, 8'h00); #1;
        n_checks++; if (mem_addr !== 5'd5) $display("FAIL rd_mem_addr: got %0d expected 5", mem_addr); else n_pass++;
        n_checks++; if (mem_wen !== 1'b0) $display("FAIL rd_mem_wen: got %b expected 0", mem_wen); else n_pass++;
        n_checks++; if (rvalid0 !== 1'b0) $display("FAIL rd_early_rvalid: got %b expected 0", rvalid0); else n_pass++;
        tick(); #1;
        n_checks++; if (rvalid0 !== 1'b1) $display("FAIL rd_rvalid0: got %b expected 1", rvalid0); else n_pass++;
        n_checks++; if (rdata !== 8'hA5) $display("FAIL rd_rdata: got %0h expected a5", rdata); else n_pass++;
        n_checks++; if (rvalid1 !== 1'b0) $display("FAIL rd_rvalid1: got %b expected 0", rvalid1); else n_pass++;
        tick(); #1;
        n_checks++; if (rvalid0 !== 1'b0) $display("FAIL rd_rvalid_pulse: got %b expected 0", rvalid0); else n_pass++;
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_gnt [4];
        exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b01;
        do_reset();
        tick();
        drive0(1'b1, 1'b1, 1'b0, 5'd1, 8'h11);
        drive1(1'b1, 1'b1, 1'b0, 5'd2, 8'h22);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if ({gnt0, gnt1} !== exp_gnt[i]) $display("FAIL rr_gnt%0d: got %b%b expected %b", i, gnt0, gnt1, exp_gnt[i]); else n_pass++;
            if (i > 0) begin
                n_checks++; if (mem_wen !== 1'b1) $display("FAIL rr_wen%0d: got %b expected 1", i, mem_wen); else n_pass++;
            end
            tick();
        end
        drive0(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        drive1(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        #1;
        n_checks++; if ({mem_wen, mem_addr, mem_din} !== {1'b1, 5'd2, 8'h22}) $display("FAIL rr_last_write: got %b/%0d/%0h expected 1/2/22", mem_wen, mem_addr, mem_din); else n_pass++;
        tick(); #1;
        n_checks++; if ({mem_wen, mem_addr, mem_din} !== {1'b0, 5'd2, 8'h22}) $display("FAIL rr_idle_hold: got %b/%0d/%0h expected 0/2/22", mem_wen, mem_addr, mem_din); else n_pass++;
        n_checks++; if (mem_model[1] !== 8'h11) $display("FAIL rr_mem1: got %0h expected 11", mem_model[1]); else n_pass++;
        n_checks++; if (mem_model[2] !== 8'h22) $display("FAIL rr_mem2: got %0h expected 22", mem_model[2]); else n_pass++;
    endtask

    task automatic test_read_after_write;
        tick(); drive1(1'b1, 1'b1, 1'b0, 5'd7, 8'h3C); #1;
        n_checks++; if ({gnt0, gnt1} !== 2'b01) $display("FAIL raw_gnt1: got %b%b expected 01", gnt0, gnt1); else n_pass++;
        tick();
        drive1(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        drive0(1'b1, 1'b0, 1'b0, 5'd7, 8'h00);
        #1;
        n_checks++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL raw_gnt0: got %b%b expected 10", gnt0, gnt1); else n_pass++;
        n_checks++; if ({mem_wen, mem_addr, mem_din} !== {1'b1, 5'd7, 8'h3C}) $display("FAIL raw_write: got %b/%0d/%0h expected 1/7/3c", mem_wen, mem_addr, mem_din); else n_pass++;
        tick(); drive0(1'b0, 1'b0, 1'b0, 5'd0, 8'h00); #1;
        n_checks++; if ({mem_wen, mem_addr} !== {1'b0, 5'd7}) $display("FAIL raw_read_req: got %b/%0d expected 0/7", mem_wen, mem_addr); else n_pass++;
        tick(); #1;
        n_checks++; if ({rvalid0, rvalid1, rdata} !== {2'b10, 8'h3C}) $display("FAIL raw_rdata: got %b%b/%0h expected 10/3c", rvalid0, rvalid1, rdata); else n_pass++;
    endtask

    task automatic test_lock_release;
        do_reset();
        tick(); drive0(1'b1, 1'b0, 1'b1, 5'd9, 8'h00); #1;
        n_checks++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL lk_gnt0: got %b%b expected 10", gnt0, gnt1); else n_pass++;
        tick();
        drive0(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        drive1(1'b1, 1'b0, 1'b0, 5'd4, 8'h00);
        #1;
        n_checks++; if (gnt1 !== 1'b0) $display("FAIL lk_block1: got %b expected 0", gnt1); else n_pass++;
        tick(); drive0(1'b1, 1'b1, 1'b0, 5'd9, 8'h99); #1;
        n_checks++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL lk_unlock_gnt: got %b%b expected 10", gnt0, gnt1); else n_pass++;
        n_checks++; if ({rvalid0, rdata} !== {1'b1, 8'h90}) $display("FAIL lk_rdata: got %b/%0h expected 1/90", rvalid0, rdata); else n_pass++;
        n_checks++; if (lock_timeout !== 1'b0) $display("FAIL lk_no_timeout: got %b expected 0", lock_timeout); else n_pass++;
        tick(); drive0(1'b0, 1'b0, 1'b0, 5'd0, 8'h00); #1;
        n_checks++; if ({gnt0, gnt1} !== 2'b01) $display("FAIL lk_after_release: got %b%b expected 01", gnt0, gnt1); else n_pass++;
        tick(); drive1(1'b0, 1'b0, 1'b0, 5'd0, 8'h00); #1;
        n_checks++; if ({mem_wen, mem_addr} !== {1'b0, 5'd4}) $display("FAIL lk_p1_req: got %b/%0d expected 0/4", mem_wen, mem_addr); else n_pass++;
        tick(); #1;
        n_checks++; if ({rvalid1, rdata} !== {1'b1, 8'h44}) $display("FAIL lk_p1_rdata: got %b/%0h expected 1/44", rvalid1, rdata); else n_pass++;
        n_checks++; if (mem_model[9] !== 8'h99) $display("FAIL lk_mem9: got %0h expected 99", mem_model[9]); else n_pass++;
    endtask

    task automatic test_lock_timeout;
        int bad;
        bad = 0;
        do_reset();
        tick(); drive0(1'b1, 1'b0, 1'b1, 5'd0, 8'h00); #1;
        n_checks++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL to_lock_gnt: got %b%b expected 10", gnt0, gnt1); else n_pass++;
        tick();
        drive0(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        drive1(1'b1, 1'b0, 1'b0, 5'd3, 8'h00);
        for (int i = 0; i < 8; i++) begin
            #1;
            if (gnt1 !== 1'b0 || lock_timeout !== 1'b0) bad++;
            tick();
        end
        #1;
        n_checks++; if (bad !== 0) $display("FAIL to_held: got %0d bad cycles expected 0", bad); else n_pass++;
        n_checks++; if ({lock_timeout, gnt1} !== 2'b10) $display("FAIL to_pulse: got %b%b expected 10", lock_timeout, gnt1); else n_pass++;
        tick(); drive0(1'b1, 1'b0, 1'b0, 5'd0, 8'h00); #1;
        n_checks++; if ({lock_timeout, gnt0, gnt1} !== 3'b001) $display("FAIL to_release: got %b%b%b expected 001", lock_timeout, gnt0, gnt1); else n_pass++;
        tick(); drive1(1'b0, 1'b0, 1'b0, 5'd0, 8'h00); #1;
        n_checks++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL to_next0: got %b%b expected 10", gnt0, gnt1); else n_pass++;
        tick(); drive0(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        tick();
        tick();
    endtask

    task automatic test_reset_inflight;
        int bad;
        bad = 0;
        tick(); drive0(1'b1, 1'b0, 1'b0, 5'd5, 8'h00); #1;
        n_checks++; if (gnt0 !== 1'b1) $display("FAIL ri_gnt0: got %b expected 1", gnt0); else n_pass++;
        tick(); drive0(1'b0, 1'b0, 1'b0, 5'd0, 8'h00); #1;
        n_checks++; if (mem_addr !== 5'd5) $display("FAIL ri_pending: got %0d expected 5", mem_addr); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if ({mem_addr, mem_wen, mem_din} !== 14'd0) $display("FAIL ri_mem_out: got %0d/%b/%0h expected 0/0/0", mem_addr, mem_wen, mem_din); else n_pass++;
        n_checks++; if ({rvalid0, rvalid1, lock_timeout} !== 3'b000) $display("FAIL ri_ctrl_out: got %b%b%b expected 000", rvalid0, rvalid1, lock_timeout); else n_pass++;
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) bad++;
            tick();
        end
        n_checks++; if (bad !== 0) $display("FAIL ri_no_rvalid: got %0d bad cycles expected 0", bad); else n_pass++;
        drive1(1'b1, 1'b0, 1'b0, 5'd5, 8'h00); #1;
        n_checks++; if ({gnt0, gnt1} !== 2'b01) $display("FAIL ri_gnt1: got %b%b expected 01", gnt0, gnt1); else n_pass++;
        tick(); drive1(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        tick(); #1;
        n_checks++; if ({rvalid1, rdata} !== {1'b1, 8'hA5}) $display("FAIL ri_rdata: got %b/%0h expected 1/a5", rvalid1, rdata); else n_pass++;
    endtask

    initial begin
        rst = 1'b0;
        load_en = 1'b1;
        drive0(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        drive1(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_read_after_write();
        test_lock_release();
        test_lock_timeout();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
